// File: rtl/weighted_lif_neuron.sv
// rtl/weighted_lif_neuron.sv - multi-synapse leaky integrate-and-fire neuron with refractory period
module weighted_lif_neuron #(
   parameter int WIDTH      = 16,
   parameter int N_INPUTS   = 4,
   parameter int THRESHOLD  = 100,
   parameter int LEAK_NUM   = 15,
   parameter int LEAK_SHIFT = 4,
   parameter int RESET_MODE = 0,
   parameter int RESET_VAL  = 0,
   parameter int REFRACT    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [N_INPUTS-1:0]       in_spikes,
   input  logic [N_INPUTS*WIDTH-1:0] weights,
   output logic                      spike,
   output logic [WIDTH-1:0]          potential,
   output logic                      refractory
);

   // Product and synapse-sum widths; all arithmetic is done at a common width
   // wide enough for both plus headroom for the add and the threshold subtract.
   localparam int PW = WIDTH + $clog2(LEAK_NUM + 1) + 1;
   localparam int SW = WIDTH + $clog2(N_INPUTS) + 1;
   localparam int EW = ((PW > SW) ? PW : SW) + 2;
   localparam int CW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

   localparam logic [0:0] INTEGRATE  = 1'b0;
   localparam logic [0:0] REFRACTORY = 1'b1;

   localparam logic signed [EW-1:0] MAXV  = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0] MINV  = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic signed [EW-1:0] THR   = EW'(THRESHOLD);
   localparam logic signed [EW-1:0] KLEAK = EW'(LEAK_NUM);
   localparam logic [WIDTH-1:0]     RVAL  = WIDTH'(RESET_VAL);

   logic [0:0]           state;
   logic [CW-1:0]        cnt;
   logic signed [EW-1:0] p_ext;
   logic signed [EW-1:0] prod;
   logic signed [EW-1:0] leaked;
   logic signed [EW-1:0] syn;
   logic signed [EW-1:0] sum;
   logic signed [EW-1:0] next_ext;
   logic signed [EW-1:0] sub;
   logic [WIDTH-1:0]     next_sat;
   logic [WIDTH-1:0]     post_fire;
   logic                 fire;

   // Clamp a wide signed value into the WIDTH-bit two's complement range.
   function automatic logic [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
      if (v > MAXV)
         sat = MAXV[WIDTH-1:0];
      else if (v < MINV)
         sat = MINV[WIDTH-1:0];
      else
         sat = v[WIDTH-1:0];
   endfunction

   // Leak, synaptic sum, saturation, threshold test and post-fire value.
   always_comb begin
      p_ext  = {{(EW-WIDTH){potential[WIDTH-1]}}, potential};
      prod   = p_ext * KLEAK;
      leaked = prod >>> LEAK_SHIFT;
      syn    = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (in_spikes[i])
            syn = syn + {{(EW-WIDTH){weights[i*WIDTH+WIDTH-1]}}, weights[i*WIDTH +: WIDTH]};
      end
      sum       = leaked + syn;
      next_sat  = sat(sum);
      next_ext  = {{(EW-WIDTH){next_sat[WIDTH-1]}}, next_sat};
      fire      = (next_ext >= THR);
      sub       = next_ext - THR;
      post_fire = (RESET_MODE == 1) ? sat(sub) : RVAL;
   end

   // Membrane potential, fire pulse and refractory countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INTEGRATE;
         cnt       <= '0;
         potential <= '0;
         spike     <= 1'b0;
      end else begin
         spike <= 1'b0;
         if (en) begin
            if (state == INTEGRATE) begin
               if (fire) begin
                  spike     <= 1'b1;
                  potential <= post_fire;
                  if (REFRACT > 0) begin
                     state <= REFRACTORY;
                     cnt   <= CW'(REFRACT);
                  end
               end else begin
                  potential <= next_sat;
               end
            end else begin
               if (cnt == CW'(1))
                  state <= INTEGRATE;
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

   assign refractory = (state == REFRACTORY);

endmodule

// File: tb/tb_weighted_lif_neuron.sv
// tb/tb_weighted_lif_neuron.sv - directed self-checking bench for weighted_lif_neuron
module tb_weighted_lif_neuron;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;

   logic [3:0]  in_a, in_b, in_c, in_d;
   logic [63:0] w_a, w_c, w_d;
   logic [31:0] w_b;
   logic        spike_a, spike_b, spike_c, spike_d;
   logic        refr_a, refr_b, refr_c, refr_d;
   logic [15:0] pot_a, pot_c, pot_d;
   logic [7:0]  pot_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   weighted_lif_neuron dut_a (
      .clk(clk), .rst(rst), .en(en), .in_spikes(in_a), .weights(w_a),
      .spike(spike_a), .potential(pot_a), .refractory(refr_a)
   );

   weighted_lif_neuron #(.WIDTH(8)) dut_b (
      .clk(clk), .rst(rst), .en(en), .in_spikes(in_b), .weights(w_b),
      .spike(spike_b), .potential(pot_b), .refractory(refr_b)
   );

   weighted_lif_neuron #(.RESET_MODE(1)) dut_c (
      .clk(clk), .rst(rst), .en(en), .in_spikes(in_c), .weights(w_c),
      .spike(spike_c), .potential(pot_c), .refractory(refr_c)
   );

   weighted_lif_neuron #(.REFRACT(0)) dut_d (
      .clk(clk), .rst(rst), .en(en), .in_spikes(in_d), .weights(w_d),
      .spike(spike_d), .potential(pot_d), .refractory(refr_d)
   );

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   initial begin
      int leak_exp [4] = '{75, 70, 65, 60};

      rst  = 1'b1;
      en   = 1'b1;
      in_a = '0; in_b = '0; in_c = '0; in_d = '0;
      w_a  = '0; w_b  = '0; w_c  = '0; w_d  = '0;
      #12;
      check("rst_pot", $signed(pot_a), 0);
      check("rst_spike", spike_a, 0);
      check("rst_refr", refr_a, 0);
      rst = 1'b0;

      // integrate to 80, fire at 155, two refractory cycles, resume
      w_a  = {4{16'd40}};
      in_a = 4'b0011;
      tick(); check("s1_p80", $signed(pot_a), 80); check("s1_nospk", spike_a, 0);
      tick(); check("s1_fire", spike_a, 1); check("s1_pfire", $signed(pot_a), 0); check("s1_refr1", refr_a, 1);
      tick(); check("s1_refr2", refr_a, 1); check("s1_spk_off", spike_a, 0); check("s1_phold", $signed(pot_a), 0);
      tick(); check("s1_refr_end", refr_a, 0); check("s1_p0", $signed(pot_a), 0);
      tick(); check("s1_resume", $signed(pot_a), 80); check("s1_resume_spk", spike_a, 0);

      // leak only from 80
      in_a = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("s2_leak", $signed(pot_a), leak_exp[i]);
         check("s2_nospk", spike_a, 0);
      end

      // negative weight, floor rounding of the leak
      do_reset();
      w_a  = {16'd0, 16'd0, 16'd0, 16'hffd8};
      in_a = 4'b0001;
      tick(); check("s3_neg40", $signed(pot_a), -40);
      tick(); check("s3_neg78", $signed(pot_a), -78);

      // 8-bit neuron pinned at the negative floor
      w_b  = {4{8'h9c}};
      in_b = 4'hf;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("s3_floor", $signed(pot_b), -128);
         check("s3_floor_spk", spike_b, 0);
      end
      in_b = 4'h0;

      // subtract-threshold reset mode
      do_reset();
      w_c  = {4{16'd40}};
      in_c = 4'b0011;
      tick(); check("s4_p80", $signed(pot_c), 80);
      tick(); check("s4_fire", spike_c, 1); check("s4_p55", $signed(pot_c), 55); check("s4_refr", refr_c, 1);
      tick();
      tick(); check("s4_hold55", $signed(pot_c), 55); check("s4_refr_end", refr_c, 0);
      tick(); check("s4_refire", spike_c, 1); check("s4_p31", $signed(pot_c), 31);

      // no refractory period: fires on every edge under sustained drive
      w_d  = {48'd0, 16'd100};
      in_d = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("s4_r0_spk", spike_d, 1);
         check("s4_r0_pot", $signed(pot_d), 0);
         check("s4_r0_refr", refr_d, 0);
      end
      in_d = 4'b0000;

      // enable low freezes the refractory countdown
      do_reset();
      w_a  = {4{16'd40}};
      in_a = 4'b0011;
      tick(); check("s5_p80", $signed(pot_a), 80);
      tick(); check("s5_fire", spike_a, 1); check("s5_refr", refr_a, 1);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("s5_frz_refr", refr_a, 1);
         check("s5_frz_pot", $signed(pot_a), 0);
         check("s5_frz_spk", spike_a, 0);
      end
      en = 1'b1;
      tick(); check("s5_refr_cont", refr_a, 1);
      tick(); check("s5_refr_done", refr_a, 0);
      tick(); check("s5_resume", $signed(pot_a), 80);

      // asynchronous reset between edges during refractory
      do_reset();
      tick(); check("s6_p80", $signed(pot_a), 80); check("s6_c_p80", $signed(pot_c), 80);
      tick(); check("s6_fire", spike_a, 1); check("s6_c_p55", $signed(pot_c), 55); check("s6_c_refr", refr_c, 1);
      #2;
      rst = 1'b1;
      #1;
      check("s6_rst_spk", spike_a, 0);
      check("s6_rst_refr", refr_a, 0);
      check("s6_rst_pot", $signed(pot_a), 0);
      check("s6_rst_c_pot", $signed(pot_c), 0);
      check("s6_rst_c_refr", refr_c, 0);
      #2;
      rst = 1'b0;
      tick(); check("s6_post_p80", $signed(pot_a), 80);
      tick(); check("s6_post_fire", spike_a, 1); check("s6_post_pot", $signed(pot_a), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
